// File: rtl/tmc_spi_pkg.sv
// Shared types and constants for the TMC-style multi-channel SPI master.
package tmc_spi_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Status byte returned when the request names a channel that does not exist.
  localparam logic [7:0] STATUS_BAD_CH = 8'hFF;

  // Datagram length: one write flag, the register address, the register data.
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/tmc_spi_bit_timer.sv
// SCLK bit-period timer: divides clk into low/high half periods and counts bits.
// fall_tick marks the clk edge that drives sclk 1->0, rise_tick the edge that
// drives it 0->1, and bit_done marks the end of the high half of the last bit.
module tmc_spi_bit_timer #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  output logic fall_tick,
  output logic rise_tick,
  output logic bit_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             high_half;
  logic [BIT_W-1:0] bit_cnt;
  logic             half_end;
  logic             last_bit;

  assign half_end  = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign rise_tick = half_end && !high_half;
  // The first falling edge is requested by the sequencer as it leaves SETUP;
  // every later one follows the high half of the previous bit.
  assign fall_tick = start || (half_end && high_half && !last_bit);
  assign bit_done  = half_end && high_half && last_bit;

  // Divider and bit counter; held cleared whenever the shift phase is inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      high_half <= 1'b0;
      bit_cnt   <= '0;
    end else if (!en) begin
      div_cnt   <= '0;
      high_half <= 1'b0;
      bit_cnt   <= '0;
    end else if (half_end) begin
      div_cnt   <= '0;
      high_half <= !high_half;
      if (high_half) bit_cnt <= bit_cnt + BIT_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tmc_spi_master.sv
// Multi-channel SPI master issuing 40-bit TMC5130-style datagrams (mode 3).
// Request handshake: a request transfers on a clk edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE and the request
// inputs are ignored on every other edge. resp_valid pulses for one cycle per
// accepted request and resp_status/resp_data hold until the next completion.
module tmc_spi_master
  import tmc_spi_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int ADDR_W   = 7,
  parameter  int DATA_W   = 32,
  parameter  int CLK_DIV  = 4,
  parameter  int CS_SETUP = 4,
  parameter  int CS_IDLE  = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [7:0]        resp_status,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CH-1:0] csn,
  output logic              mosi,
  input  logic              miso
);

  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int CH_SLOTS   = 1 << CH_W;
  localparam int WAIT_MAX   = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
  localparam int WAIT_W     = $clog2(WAIT_MAX + 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    bad_q;
  logic [FRAME_BITS-1:0]   tx_q;
  logic [FRAME_BITS-1:0]   rx_q;
  logic [CH_SLOTS-1:0]     ch_map;
  logic [NUM_CH-1:0]       sel_n;
  logic                    ch_ok;
  logic                    accept;
  logic                    setup_done;
  logic                    hold_done;
  logic                    gap_done;
  logic                    timer_en;
  logic                    timer_start;
  logic                    fall_tick;
  logic                    rise_tick;
  logic                    bit_done;

  // Channel-exists map so an out-of-range code never needs a runtime compare.
  for (genvar i = 0; i < CH_SLOTS; i++) begin : g_ch_map
    assign ch_map[i] = (i < NUM_CH);
  end

  assign ch_ok      = ch_map[req_ch];
  assign accept     = req_valid && req_ready;
  assign setup_done = (wait_cnt == WAIT_W'(CS_SETUP - 1));
  assign hold_done  = (wait_cnt == WAIT_W'(CS_SETUP - 1));
  assign gap_done   = (wait_cnt == WAIT_W'(CS_IDLE - 1));

  tmc_spi_bit_timer #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (timer_en),
    .start    (timer_start),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick),
    .bit_done (bit_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a bad channel spends a single cycle in GAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ch_ok ? ST_SETUP : ST_GAP;
      ST_SETUP: if (setup_done) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_done) state_d = ST_HOLD;
      ST_HOLD:  if (hold_done) state_d = ST_GAP;
      ST_GAP:   if (bad_q || gap_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and timer controls.
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    timer_en    = (state_q == ST_SHIFT);
    timer_start = (state_q == ST_SETUP) && setup_done;
  end

  // Dwell counter for SETUP/HOLD/GAP, restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt <= '0;
    else if (state_d != state_q) wait_cnt <= '0;
    else if (state_q != ST_IDLE) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Active-low select pattern for the requested channel.
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ch == CH_W'(i)) sel_n[i] = 1'b0;
    end
  end

  // Shift registers, pin registers and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi        <= 1'b0;
      sclk        <= 1'b1;
      csn         <= '1;
      resp_valid  <= 1'b0;
      resp_status <= '0;
      resp_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        bad_q <= !ch_ok;
        tx_q  <= {req_wr, req_addr, req_data};
        if (ch_ok) begin
          csn  <= sel_n;
          mosi <= req_wr;
        end else begin
          resp_valid  <= 1'b1;
          resp_status <= STATUS_BAD_CH;
          resp_data   <= '0;
        end
      end
      // Falling sclk: present the next bit (the first fall re-presents the MSB).
      if (fall_tick) begin
        sclk <= 1'b0;
        mosi <= tx_q[FRAME_BITS-1];
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end
      // Rising sclk: sample the chip's reply.
      if (rise_tick) begin
        sclk <= 1'b1;
        rx_q <= {rx_q[FRAME_BITS-2:0], miso};
      end
      if ((state_q == ST_HOLD) && hold_done) begin
        csn         <= '1;
        resp_valid  <= 1'b1;
        resp_status <= rx_q[FRAME_BITS-1 -: 8];
        resp_data   <= rx_q[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_tmc_spi_master.sv
// Directed bench for tmc_spi_master: a 4-channel instance with a chip model,
// a 3-channel instance for bad-channel handling and a fast 1-channel instance.
module tb_tmc_spi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- main instance (defaults) ----------------
  logic        req_valid, req_ready, req_wr;
  logic [1:0]  req_ch;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        resp_valid, busy, sclk, mosi;
  logic        miso = 1'b0;
  logic [7:0]  resp_status;
  logic [31:0] resp_data;
  logic [3:0]  csn;

  tmc_spi_master dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data),
    .busy(busy), .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso)
  );

  // ---------------- 3-channel instance ----------------
  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [1:0]  b_req_ch;
  logic [6:0]  b_req_addr;
  logic [31:0] b_req_data;
  logic        b_resp_valid, b_busy, b_sclk, b_mosi;
  logic        b_miso;
  logic [7:0]  b_resp_status;
  logic [31:0] b_resp_data;
  logic [2:0]  b_csn;

  tmc_spi_master #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_ch(b_req_ch), .req_wr(b_req_wr), .req_addr(b_req_addr), .req_data(b_req_data),
    .resp_valid(b_resp_valid), .resp_status(b_resp_status), .resp_data(b_resp_data),
    .busy(b_busy), .sclk(b_sclk), .csn(b_csn), .mosi(b_mosi), .miso(b_miso)
  );

  // ---------------- 1-channel fast instance ----------------
  logic        c_req_valid, c_req_ready, c_req_wr;
  logic [0:0]  c_req_ch;
  logic [6:0]  c_req_addr;
  logic [31:0] c_req_data;
  logic        c_resp_valid, c_busy, c_sclk, c_mosi;
  logic        c_miso;
  logic [7:0]  c_resp_status;
  logic [31:0] c_resp_data;
  logic [0:0]  c_csn;

  tmc_spi_master #(.NUM_CH(1), .CLK_DIV(2), .CS_SETUP(4)) dut1 (
    .clk(clk), .reset(rst), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_ch(c_req_ch), .req_wr(c_req_wr), .req_addr(c_req_addr), .req_data(c_req_data),
    .resp_valid(c_resp_valid), .resp_status(c_resp_status), .resp_data(c_resp_data),
    .busy(c_busy), .sclk(c_sclk), .csn(c_csn), .mosi(c_mosi), .miso(c_miso)
  );

  // ---------------- chip model / pin monitor (main instance) ----------------
  logic [39:0] miso_word = 40'h0;
  int          miso_idx  = 39;
  logic [39:0] mosi_cap  = 40'h0;
  int          rise_cnt  = 0;

  // Chip shifts its reply out MSB first on each falling sclk while selected.
  always @(negedge sclk) begin
    if (csn != 4'hF) begin
      miso     = miso_word[miso_idx];
      miso_idx = (miso_idx == 0) ? 39 : miso_idx - 1;
    end
  end

  // Record mosi on each rising sclk while a chip is selected.
  always @(posedge sclk) begin
    if (csn != 4'hF) begin
      mosi_cap = {mosi_cap[38:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request to the main instance, then watch until its response.
  task automatic run_frame(input logic [1:0] ch, input logic wr, input logic [6:0] addr,
                           input logic [31:0] data, output int lat, output int lowc,
                           output logic [3:0] low_or, output int multi, output int rises);
    int  r0;
    bit  got;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ch = ch; req_wr = wr; req_addr = addr; req_data = data;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    r0 = rise_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; lowc = 0; low_or = 4'h0; multi = 0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      if (sclk == 1'b0) lowc++;
      low_or = low_or | ~csn;
      if ($countones(~csn) > 1) multi++;
      if (resp_valid) begin
        lat = cyc;
        break;
      end
    end
    rises = rise_cnt - r0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_ch = 0; req_wr = 0; req_addr = 0; req_data = 0;
    b_req_valid = 0; b_req_ch = 0; b_req_wr = 0; b_req_addr = 0; b_req_data = 0; b_miso = 0;
    c_req_valid = 0; c_req_ch = 0; c_req_wr = 0; c_req_addr = 0; c_req_data = 0; c_miso = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (csn !== 4'hF) begin n_fail++; $display("FAIL reset_csn got=%h exp=f", csn); end
    n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk got=%b exp=1", sclk); end
    n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_status !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h exp=00", resp_status); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", resp_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_checks++; if (b_csn !== 3'b111 || c_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn_others got=%b/%b exp=111/1", b_csn, c_csn); end
  endtask

  task automatic test_write();
    int lat, lowc, multi, rises;
    logic [3:0] low_or;
    miso_word = 40'h01_0000_0000;
    run_frame(2'd0, 1'b1, 7'h00, 32'h0000_0202, lat, lowc, low_or, multi, rises);
    n_checks++; if (lat != 329) begin n_fail++; $display("FAIL wr_latency got=%0d exp=329", lat); end
    n_checks++; if (mosi_cap !== 40'h80_0000_0202) begin n_fail++; $display("FAIL wr_mosi got=%h exp=8000000202", mosi_cap); end
    n_checks++; if (low_or !== 4'b0001) begin n_fail++; $display("FAIL wr_csn_used got=%b exp=0001", low_or); end
    n_checks++; if (multi != 0) begin n_fail++; $display("FAIL wr_multi_csn got=%0d exp=0", multi); end
    n_checks++; if (rises != 40) begin n_fail++; $display("FAIL wr_sclk_rises got=%0d exp=40", rises); end
    n_checks++; if (lowc != 160) begin n_fail++; $display("FAIL wr_sclk_low_cycles got=%0d exp=160", lowc); end
    n_checks++; if (resp_status !== 8'h01) begin n_fail++; $display("FAIL wr_status got=%h exp=01", resp_status); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL wr_data got=%h exp=0", resp_data); end
    n_checks++; if (csn !== 4'hF) begin n_fail++; $display("FAIL wr_csn_at_resp got=%h exp=f", csn); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_resp_one_cycle got=%b exp=0", resp_valid); end
    n_checks++; if (resp_status !== 8'h01) begin n_fail++; $display("FAIL wr_status_hold got=%h exp=01", resp_status); end
  endtask

  task automatic test_read();
    int lat, lowc, multi, rises;
    logic [3:0] low_or;
    repeat (12) @(negedge clk);
    miso_word = 40'h09_1234_5678;
    run_frame(2'd2, 1'b0, 7'h21, 32'hA5A5_A5A5, lat, lowc, low_or, multi, rises);
    n_checks++; if (lat != 329) begin n_fail++; $display("FAIL rd_latency got=%0d exp=329", lat); end
    n_checks++; if (mosi_cap !== 40'h21_A5A5_A5A5) begin n_fail++; $display("FAIL rd_mosi got=%h exp=21a5a5a5a5", mosi_cap); end
    n_checks++; if (low_or !== 4'b0100) begin n_fail++; $display("FAIL rd_csn_used got=%b exp=0100", low_or); end
    n_checks++; if (resp_status !== 8'h09) begin n_fail++; $display("FAIL rd_status got=%h exp=09", resp_status); end
    n_checks++; if (resp_data !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data got=%h exp=12345678", resp_data); end
  endtask

  task automatic test_back_to_back();
    int  high, ready_at, lat2, pulses;
    bit  got;
    logic [3:0] low_or;
    repeat (12) @(negedge clk);
    miso_word = 40'h0A_CAFE_F00D;
    pulses = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_ch = 2'd0; req_wr = 1'b1; req_addr = 7'h10; req_data = 32'h1111_2222;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (req_ready) got = 1; end
    @(posedge clk); #1;
    req_ch = 2'd3; req_addr = 7'h11; req_data = 32'h3333_4444;
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin @(negedge clk); if (resp_valid) got = 1; end
    if (got) pulses++;
    n_checks++; if (resp_status !== 8'h0A || resp_data !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL b2b_first_resp got=%h_%h exp=0a_cafef00d", resp_status, resp_data); end
    miso_word = 40'h0B_0BAD_BEEF;
    high = (csn == 4'hF) ? 1 : 0;
    ready_at = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (csn == 4'hF) high++;
      if (resp_valid) pulses++;
      if (req_ready) begin ready_at = n; break; end
    end
    n_checks++; if (ready_at != 8) begin n_fail++; $display("FAIL b2b_accept_delay got=%0d exp=8", ready_at); end
    n_checks++; if (high != 9) begin n_fail++; $display("FAIL b2b_csn_high_cycles got=%0d exp=9", high); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (csn !== 4'b0111) begin n_fail++; $display("FAIL b2b_second_csn got=%b exp=0111", csn); end
    low_or = ~csn; lat2 = -1;
    for (int cyc = 2; cyc <= 1000; cyc++) begin
      @(negedge clk);
      low_or = low_or | ~csn;
      if (resp_valid) begin lat2 = cyc; pulses++; break; end
    end
    n_checks++; if (lat2 != 329) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=329", lat2); end
    n_checks++; if (low_or !== 4'b1000) begin n_fail++; $display("FAIL b2b_second_csn_used got=%b exp=1000", low_or); end
    n_checks++; if (resp_status !== 8'h0B || resp_data !== 32'h0BAD_BEEF) begin
      n_fail++; $display("FAIL b2b_second_resp got=%h_%h exp=0b_0badbeef", resp_status, resp_data); end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_resp_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_mid_shift();
    bit got;
    int seen;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b1; req_ch = 2'd1; req_wr = 1'b1; req_addr = 7'h6C; req_data = 32'h0001_0005;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (req_ready) got = 1; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (csn !== 4'b1101) begin n_fail++; $display("FAIL rst_mid_csn_before got=%b exp=1101", csn); end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (sclk == 1'b0) got = 1; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (csn !== 4'hF) begin n_fail++; $display("FAIL rst_mid_csn got=%b exp=1111", csn); end
    n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sclk got=%b exp=1", sclk); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp got=%b exp=0", resp_valid); end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (resp_valid) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen); end
  endtask

  task automatic test_bad_channel();
    bit got;
    int lat;
    logic [2:0] low_or;
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_ch = 2'd3; b_req_wr = 1'b1; b_req_addr = 7'h01; b_req_data = 32'hDEAD_0001;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (b_req_ready) got = 1; end
    @(posedge clk); #1;
    b_req_ch = 2'd1; b_req_wr = 1'b0; b_req_addr = 7'h02;
    @(negedge clk);
    n_checks++; if (b_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bad_resp_valid got=%b exp=1", b_resp_valid); end
    n_checks++; if (b_resp_status !== 8'hFF) begin n_fail++; $display("FAIL bad_status got=%h exp=ff", b_resp_status); end
    n_checks++; if (b_resp_data !== 32'h0) begin n_fail++; $display("FAIL bad_data got=%h exp=0", b_resp_data); end
    n_checks++; if (b_req_ready !== 1'b0 || b_csn !== 3'b111 || b_sclk !== 1'b1) begin
      n_fail++; $display("FAIL bad_cycle1_pins got=rdy%b csn%b sclk%b exp=rdy0 csn111 sclk1", b_req_ready, b_csn, b_sclk); end
    @(negedge clk);
    n_checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0 || b_csn !== 3'b111) begin
      n_fail++; $display("FAIL bad_cycle2 got=rdy%b resp%b csn%b exp=rdy1 resp0 csn111", b_req_ready, b_resp_valid, b_csn); end
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = -1; low_or = 3'b000;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      low_or = low_or | ~b_csn;
      if (b_resp_valid) begin lat = cyc; break; end
    end
    n_checks++; if (lat != 329) begin n_fail++; $display("FAIL bad_next_latency got=%0d exp=329", lat); end
    n_checks++; if (low_or !== 3'b010) begin n_fail++; $display("FAIL bad_next_csn_used got=%b exp=010", low_or); end
    n_checks++; if (b_resp_status !== 8'h00) begin n_fail++; $display("FAIL bad_next_status got=%h exp=00", b_resp_status); end
  endtask

  task automatic test_single_ch_fast();
    bit got;
    int lat, lowc;
    logic low_seen;
    @(posedge clk); #1;
    c_req_valid = 1'b1; c_req_ch = 1'b0; c_req_wr = 1'b0; c_req_addr = 7'h04; c_req_data = 32'h0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (c_req_ready) got = 1; end
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    lat = -1; lowc = 0; low_seen = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      if (c_sclk == 1'b0) lowc++;
      if (c_csn == 1'b0) low_seen = 1'b1;
      if (c_resp_valid) begin lat = cyc; break; end
    end
    n_checks++; if (lat != 169) begin n_fail++; $display("FAIL fast_latency got=%0d exp=169", lat); end
    n_checks++; if (lowc != 80) begin n_fail++; $display("FAIL fast_sclk_low_cycles got=%0d exp=80", lowc); end
    n_checks++; if (low_seen !== 1'b1) begin n_fail++; $display("FAIL fast_csn_used got=%b exp=1", low_seen); end
    n_checks++; if (c_resp_status !== 8'hFF || c_resp_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL fast_resp got=%h_%h exp=ff_ffffffff", c_resp_status, c_resp_data); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_shift();
    test_bad_channel();
    test_single_ch_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
